// File: rtl/decade_chain_ctrl_if.sv
// ---------------------------------------------------------------------------
// decade_chain_ctrl_if
// Command channel between a command source and decade_chain_ctrl.
//   cmd_valid : command present (source -> controller)
//   cmd_ready : controller can accept a command this cycle (controller -> source)
//   cmd_op    : 2'b00 START, 2'b01 STOP, 2'b10 CLEAR, 2'b11 LOAD
//   cmd_data  : packed BCD value for LOAD, digit 0 in [3:0]
// Modports: master = command source, slave = controller.
// ---------------------------------------------------------------------------
interface decade_chain_ctrl_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/decade_chain_ctrl.sv
// ---------------------------------------------------------------------------
// decade_chain_ctrl
// Sequences a chain of DIGITS cascaded BCD decade counters. Commands arrive
// over a valid/ready channel; the chain advances on an external tick while
// running and stops in DONE when the post-increment value equals target.
//
// Ports:
//   CLK      : system clock, rising edge
//   RST_N    : asynchronous active-low reset
//   tick     : count-enable pulse from the prescaler
//   bus      : command channel (decade_chain_ctrl_if.slave)
//   target   : packed BCD terminal value, sampled continuously
//   digits   : registered packed BCD count
//   running  : high while in RUN
//   done     : high while in DONE
//   wrap_out : (only with DECADE_CHAIN_CTRL_WRAP_OUT_EN) one-cycle pulse after
//              an all-9s -> all-0s increment
//
// Build option: define DECADE_CHAIN_CTRL_WRAP_OUT_EN to add wrap_out.
// ---------------------------------------------------------------------------
module decade_chain_ctrl #(
  parameter  int DIGITS = 4,
  localparam int W      = 4 * DIGITS
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  tick,
  decade_chain_ctrl_if.slave    bus,
  input  logic [W-1:0]          target,
  output logic [W-1:0]          digits,
  output logic                  running,
  output logic                  done
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
  ,
  output logic                  wrap_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_LOAD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  // Clamp every nibble above 9 down to 9 so the chain always holds legal BCD.
  function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
    end
    return r;
  endfunction

  // True when every nibble is a legal decimal digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Ripple increment: a digit advances only while every lower digit is 9.
  function automatic logic [W-1:0] bcd_incr(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = '0;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!carry) begin
        r[4*k +: 4] = v[4*k +: 4];
      end else if (v[4*k +: 4] == 4'd9) begin
        r[4*k +: 4] = 4'd0;
      end else begin
        r[4*k +: 4] = v[4*k +: 4] + 4'd1;
        carry       = 1'b0;
      end
    end
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] digits_q, digits_d;
  logic         running_q, done_q, ready_q;
  logic         accept_s;
  logic [W-1:0] inc_s;
  logic         hit_s;

`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
  logic wrap_q, wrap_d;
  logic all9_s;
  // Chain is about to roll over from all 9s if it increments this cycle.
  assign all9_s = (digits_q == {DIGITS{4'd9}});
  assign wrap_out = wrap_q;
`endif

  assign accept_s      = bus.cmd_valid && ready_q;
  assign inc_s         = bcd_incr(digits_q);
  // A target holding a non-decimal nibble can never be matched.
  assign hit_s         = (inc_s == target) && bcd_valid(target);
  assign bus.cmd_ready = ready_q;
  assign digits        = digits_q;
  assign running       = running_q;
  assign done          = done_q;

  // Next-state and next-count logic; an accepted command pre-empts a tick.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
    wrap_d   = 1'b0;
`endif
    if (accept_s) begin
      case (bus.cmd_op)
        OP_CLEAR: begin
          state_d  = S_IDLE;
          digits_d = '0;
        end
        OP_LOAD: begin
          state_d  = S_LOAD;
          digits_d = bcd_sanitize(bus.cmd_data);
        end
        OP_START: begin
          if (state_q == S_IDLE || state_q == S_PAUSE) begin
            state_d = S_RUN;
          end else begin
            state_d = state_q;
          end
        end
        OP_STOP: begin
          if (state_q == S_RUN) begin
            state_d = S_PAUSE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (state_q == S_LOAD) begin
      state_d = S_IDLE;
    end else if (state_q == S_RUN && tick) begin
      digits_d = inc_s;
      state_d  = hit_s ? S_DONE : S_RUN;
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
      wrap_d   = all9_s;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // State, count and status flags, all registered from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
      wrap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      ready_q   <= (state_d != S_LOAD);
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
      wrap_q    <= wrap_d;
`endif
    end
  end

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decade_chain_ctrl
// Directed stimulus with hand-computed expectations pushed into a queue; a
// separate monitor pops and compares each entry on the falling edge of the
// cycle it was issued for. Covers reset, counting, carry, LOAD clamping,
// terminal detect, command/tick collisions, wrap and async reset.
// ---------------------------------------------------------------------------
module tb_decade_chain_ctrl;
  localparam int W = 16;

`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
  localparam logic WX = 1'b1;
`else
  localparam logic WX = 1'b0;
`endif

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  logic         CLK   = 1'b0;
  logic         RST_N = 1'b0;
  logic         tick  = 1'b0;
  logic [W-1:0] target;
  logic [W-1:0] digits;
  logic         running;
  logic         done;
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
  logic         wrap_out;
`endif

  decade_chain_ctrl_if #(.W(W)) bus ();

  decade_chain_ctrl #(.DIGITS(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .tick    (tick),
    .bus     (bus),
    .target  (target),
    .digits  (digits),
    .running (running),
    .done    (done)
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
    ,
    .wrap_out(wrap_out)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [W-1:0] dig;
    logic        run;
    logic        dn;
    logic        rdy;
    logic        wrp;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic expect_out(input string name, input logic [W-1:0] dig,
                            input logic run, input logic dn, input logic rdy,
                            input logic wrp = 1'b0);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.dig  = dig;
    e.run  = run;
    e.dn   = dn;
    e.rdy  = rdy;
    e.wrp  = wrp;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t e;
    logic aw;
    forever begin
      @(negedge CLK);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
`ifdef DECADE_CHAIN_CTRL_WRAP_OUT_EN
        aw = wrap_out;
`else
        aw = 1'b0;
`endif
        n_chk++;
        if (digits === e.dig && running === e.run && done === e.dn &&
            bus.cmd_ready === e.rdy && aw === e.wrp) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got digits=%h run=%b done=%b ready=%b wrap=%b, want digits=%h run=%b done=%b ready=%b wrap=%b",
                   e.name, digits, running, done, bus.cmd_ready, aw,
                   e.dig, e.run, e.dn, e.rdy, e.wrp);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    target        = 16'h9999;

    // Reset state
    step(); step();
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b1);
    RST_N = 1'b1;
    step();
    expect_out("idle", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Basic count, tick held high
    send(OP_START, 16'h0);
    expect_out("start", 16'h0000, 1'b1, 1'b0, 1'b1);
    ticks(12);
    expect_out("count12", 16'h0012, 1'b1, 1'b0, 1'b1);

    // LOAD, carry, clamping
    send(OP_CLEAR, 16'h0);
    expect_out("clear", 16'h0000, 1'b0, 1'b0, 1'b1);
    send(OP_LOAD, 16'h0199);
    expect_out("load_0199", 16'h0199, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("load_done", 16'h0199, 1'b0, 1'b0, 1'b1);
    send(OP_START, 16'h0);
    ticks(1);
    expect_out("carry_0200", 16'h0200, 1'b1, 1'b0, 1'b1);
    send(OP_LOAD, 16'h0A5F);
    expect_out("load_clamp", 16'h0959, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("load_ready", 16'h0959, 1'b0, 1'b0, 1'b1);

    // Terminal detect
    target = 16'h0005;
    send(OP_CLEAR, 16'h0);
    send(OP_START, 16'h0);
    ticks(4);
    expect_out("tick4", 16'h0004, 1'b1, 1'b0, 1'b1);
    ticks(1);
    expect_out("done5", 16'h0005, 1'b0, 1'b1, 1'b1);
    ticks(3);
    expect_out("done_hold", 16'h0005, 1'b0, 1'b1, 1'b1);
    send(OP_START, 16'h0);
    expect_out("done_start", 16'h0005, 1'b0, 1'b1, 1'b1);
    send(OP_CLEAR, 16'h0);
    expect_out("done_clear", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Starting at target does not flag DONE
    target = 16'h0003;
    send(OP_LOAD, 16'h0003);
    step();
    send(OP_START, 16'h0);
    expect_out("eq_start", 16'h0003, 1'b1, 1'b0, 1'b1);
    ticks(1);
    expect_out("eq_tick", 16'h0004, 1'b1, 1'b0, 1'b1);

    // Non-decimal target never matches
    target = 16'h000A;
    send(OP_CLEAR, 16'h0);
    send(OP_START, 16'h0);
    ticks(12);
    expect_out("bad_target", 16'h0012, 1'b1, 1'b0, 1'b1);

    // STOP together with tick: command wins
    target = 16'h9999;
    send(OP_LOAD, 16'h0042);
    step();
    send(OP_START, 16'h0);
    tick = 1'b1;
    send(OP_STOP, 16'h0);
    tick = 1'b0;
    expect_out("stop_tick", 16'h0042, 1'b0, 1'b0, 1'b1);
    ticks(1);
    expect_out("pause_hold", 16'h0042, 1'b0, 1'b0, 1'b1);
    send(OP_START, 16'h0);
    ticks(1);
    expect_out("resume", 16'h0043, 1'b1, 1'b0, 1'b1);

    // All-9s wrap
    target = 16'h0500;
    send(OP_LOAD, 16'h9998);
    step();
    send(OP_START, 16'h0);
    ticks(1);
    expect_out("to_9999", 16'h9999, 1'b1, 1'b0, 1'b1);
    ticks(1);
    expect_out("wrap0", 16'h0000, 1'b1, 1'b0, 1'b1, WX);
    step();
    expect_out("wrap_end", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Wrap into target 0000
    target = 16'h0000;
    send(OP_LOAD, 16'h9999);
    step();
    send(OP_START, 16'h0);
    ticks(1);
    expect_out("wrap_done", 16'h0000, 1'b0, 1'b1, 1'b1, WX);
    step();
    expect_out("wrap_done_end", 16'h0000, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-run (LOAD issued from DONE)
    target = 16'h9999;
    send(OP_LOAD, 16'h0317);
    step();
    send(OP_START, 16'h0);
    expect_out("at0317", 16'h0317, 1'b1, 1'b0, 1'b1);
    step();
    #1;
    RST_N = 1'b0;
    expect_out("async_rst", 16'h0000, 1'b0, 1'b0, 1'b1);
    #4;
    RST_N = 1'b1;
    step();
    expect_out("post_rst", 16'h0000, 1'b0, 1'b0, 1'b1);

    step(); step();
    n_chk++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decade_chain_ctrl.md
Name: decade_chain_ctrl

Overview:
- Controller that sequences a chain of DIGITS cascaded BCD decade counters, each counting 0..9 with wrap.
- Accepts start/stop/clear/load commands over a valid/ready handshake and advances the chain on an external tick enable.
- Flags completion when the chain reaches a programmable target.
- Sits between a prescaler (tick source) and display/compare logic in the counting datapath.

Parameters:
- DIGITS, 4, number of cascaded decade digits (1..8)
- W, 4*DIGITS, derived packed BCD width; not for override

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- tick  input  1  count-enable pulse, one CLK cycle wide
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command this cycle
- cmd_op  input  2  command: 00 START, 01 STOP, 10 CLEAR, 11 LOAD
- cmd_data  input  W  packed BCD value for LOAD; digit 0 in [3:0]
- target  input  W  packed BCD terminal value, sampled continuously
- digits  output  W  registered packed BCD count
- running  output  1  high in RUN
- done  output  1  high in DONE

Behaviour:
- Reset: RST_N low asynchronously forces state=IDLE, digits=0, running=0, done=0, cmd_ready=1.
  - Deassertion takes effect on the next CLK edge.
  - Reset mid-count discards the count.
- A command is accepted on a CLK edge where cmd_valid && cmd_ready. Its effect is visible in digits/state the following cycle.
- States: IDLE, RUN, PAUSE, LOAD, DONE. running=(state==RUN), done=(state==DONE), cmd_ready=(state!=LOAD). All outputs are registered.
- IDLE:
  - START -> RUN.
  - LOAD -> LOAD.
  - CLEAR -> IDLE, digits=0.
  - STOP is ignored.
- RUN:
  - tick increments the chain.
  - STOP -> PAUSE.
  - CLEAR -> IDLE, digits=0.
  - LOAD -> LOAD.
  - START is ignored.
- PAUSE: digits hold. START -> RUN; CLEAR -> IDLE; LOAD -> LOAD; STOP is ignored.
- LOAD:
  - Lasts exactly one cycle with cmd_ready=0.
  - digits takes the sanitized captured cmd_data: any nibble >9 is clamped to 9.
  - Next state is IDLE.
- DONE:
  - digits hold and tick is ignored.
  - Only CLEAR (-> IDLE) or LOAD (-> LOAD) are acted on; START and STOP are accepted but ignored.
- Increment rule:
  - Digit 0 goes +1, with 9 -> 0.
  - Digit k goes +1 (9 -> 0) only when digits 0..k-1 are all 9.
  - All-9s wraps to all-0s and counting continues.
- Terminal detect:
  - Compare the post-increment value to target on the same edge.
  - If equal, state -> DONE on that edge. digits shows the target value and done=1 from the next cycle.
  - Detection occurs only on an incrementing tick. Starting with digits==target does not trigger DONE until the count wraps around to target again.
  - A target with any nibble >9 can never match.
- Simultaneous events: an accepted command and a tick on the same edge -> the command wins and the tick is dropped (not queued).
- tick held high for multiple cycles increments once per cycle.

Optional Feature:
- Macro: DECADE_CHAIN_CTRL_WRAP_OUT_EN.
- When defined:
  - Adds output port wrap_out (1 bit, reset 0).
  - wrap_out pulses high for exactly one cycle, the cycle after an all-9s -> all-0s increment in RUN.
  - If that increment also hits target (target all-0), both wrap_out and done assert in the same cycle.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then START, 12 ticks, DIGITS=4, target=9999 -> digits=0x0012, running=1, done=0.
- LOAD 0x0199, START, 1 tick -> digits=0x0200; LOAD 0x0A5F -> digits=0x0959 with cmd_ready=0 for exactly one cycle.
- target=0x0005, START, 5 ticks -> done=1 the cycle after the 5th tick, digits=0x0005; further ticks and START leave digits unchanged; CLEAR -> IDLE, digits=0.
- RUN at 0x0042, STOP asserted together with a tick -> PAUSE, digits stays 0x0042; START then 1 tick -> 0x0043.
- LOAD 0x9998, START, 2 ticks -> 0x0000 and still RUN. With DECADE_CHAIN_CTRL_WRAP_OUT_EN: wrap_out is a one-cycle pulse; with target=0x0000, done and wrap_out rise together.
- RST_N pulsed low asynchronously mid-RUN at 0x0317 (between edges) -> digits=0, state IDLE immediately, running=0 before the next CLK edge.
